// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory.
// Sub-word stores use read-modify-write; the pipeline is stalled until the access completes.
module mem_access_unit #(
  parameter int unsigned SIZE_DM = 128,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  output logic        stall,
  output logic        done,
  output logic [31:0] rData,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wData,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  input  logic [31:0] mem_rData,
  input  logic        mem_ready
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      lane_q;
  logic [2:0]      f3_q;
  logic            load_q;
  logic [15:0]     wdata_q;

  logic        accept;
  logic        f3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        acc_err;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        timed_out;

  assign accept    = (state_q == StIdle) & req_valid & (MemRead | MemWrite);
  assign stall     = accept | (state_q == StRd) | (state_q == StWr);
  assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    f3_ok = 1'b0;
    if (MemRead) begin
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    end
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = {2'b00, addr[31:2]} >= SIZE_DM;
    acc_err      = (MemRead & MemWrite) | ~f3_ok | misaligned | out_of_range;
  end

  // Lane extraction for loads and lane merge for RMW stores.
  always_comb begin
    shifted = mem_rData >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = mem_rData;
    endcase
    merged = mem_rData;
    if (f3_q[1:0] == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      lane_q       <= '0;
      f3_q         <= '0;
      load_q       <= 1'b0;
      wdata_q      <= '0;
      done         <= 1'b0;
      rData        <= '0;
      err          <= 1'b0;
      mem_addr     <= '0;
      mem_wData    <= '0;
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            lane_q   <= addr[1:0];
            f3_q     <= funct3;
            load_q   <= MemRead;
            wdata_q  <= wData[15:0];
            cnt_q    <= '0;
            mem_addr <= {2'b00, addr[31:2]};
            if (acc_err) begin
              err     <= 1'b1;
              done    <= 1'b1;
              rData   <= '0;
              state_q <= StDone;
            end else if (MemWrite && (funct3 == 3'b010)) begin
              mem_wData    <= wData;
              mem_MemWrite <= 1'b1;
              state_q      <= StWr;
            end else begin
              mem_MemRead <= 1'b1;
              state_q     <= StRd;
            end
          end
        end
        StRd: begin
          if (mem_ready) begin
            mem_MemRead <= 1'b0;
            if (load_q) begin
              rData   <= load_val;
              err     <= 1'b0;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              mem_wData    <= merged;
              mem_MemWrite <= 1'b1;
              cnt_q        <= '0;
              state_q      <= StWr;
            end
          end else if (timed_out) begin
            // Abort before any write so a half-finished RMW never reaches memory.
            mem_MemRead <= 1'b0;
            err         <= 1'b1;
            done        <= 1'b1;
            rData       <= '0;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWr: begin
          if (mem_ready || timed_out) begin
            mem_MemWrite <= 1'b0;
            err          <= ~mem_ready;
            done         <= 1'b1;
            rData        <= '0;
            state_q      <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wData;
  logic        stall;
  logic        done;
  logic [31:0] rData;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wData;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_rData;
  logic        mem_ready;

  logic [31:0] mem [0:127];
  logic        ready_en;

  int checks;
  int errors;
  int lat;
  int rd_hs, wr_hs, rd_cyc, strobe_cyc, overlap;
  logic [31:0] got_rdata;
  logic        got_err;
  logic        acc_stall;
  logic        stall_ok;

  mem_access_unit #(.SIZE_DM(128), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .addr(addr), .wData(wData), .stall(stall), .done(done), .rData(rData),
    .err(err), .mem_addr(mem_addr), .mem_wData(mem_wData), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .mem_rData(mem_rData), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ready = ready_en;
  assign mem_rData = mem[mem_addr[6:0]];

  always @(posedge clk) begin
    if (mem_MemRead && mem_ready) rd_hs++;
    if (mem_MemWrite && mem_ready) begin
      wr_hs++;
      mem[mem_addr[6:0]] = mem_wData;
    end
  end

  always @(negedge clk) begin
    if (mem_MemRead) rd_cyc++;
    if (mem_MemRead || mem_MemWrite) strobe_cyc++;
    if (mem_MemRead && mem_MemWrite) overlap++;
  end

  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    rd_hs = 0; wr_hs = 0; rd_cyc = 0; strobe_cyc = 0; overlap = 0;
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wData = wd;
    #1 acc_stall = stall;
    @(posedge clk);
    #1;
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wData = '0;
    lat = 0;
    stall_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (!stall) stall_ok = 1'b0;
    end
    if (done && stall) stall_ok = 1'b0;
    got_rdata = rData;
    got_err   = err;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout got done=%b after %0d cycles, expected done=1", done, lat);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({stall, done, err, mem_MemRead, mem_MemWrite} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 00000",
               {stall, done, err, mem_MemRead, mem_MemWrite});
    end
    checks++;
    if (rData !== 32'h0 || mem_addr !== 32'h0 || mem_wData !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got rData=%h mem_addr=%h mem_wData=%h expected 0", rData,
               mem_addr, mem_wData);
    end
  endtask

  task automatic test_loads;
    do_access(1'b1, 1'b0, 3'b000, 32'h0D, 32'h0);
    checks++;
    if (lat !== 2 || got_rdata !== 32'hFFFF_FFA2 || got_err !== 1'b0) begin
      errors++;
      $display("FAIL lb got lat=%0d rData=%h err=%b expected 2 ffffffa2 0", lat, got_rdata,
               got_err);
    end
    checks++;
    if (acc_stall !== 1'b1 || !stall_ok) begin
      errors++;
      $display("FAIL lb_stall got accept_stall=%b stall_ok=%b expected 1 1", acc_stall, stall_ok);
    end
    do_access(1'b1, 1'b0, 3'b101, 32'h0E, 32'h0);
    checks++;
    if (got_rdata !== 32'h0000_8091 || got_err !== 1'b0) begin
      errors++;
      $display("FAIL lhu got rData=%h err=%b expected 00008091 0", got_rdata, got_err);
    end
    do_access(1'b1, 1'b0, 3'b001, 32'h0E, 32'h0);
    checks++;
    if (got_rdata !== 32'hFFFF_8091 || got_err !== 1'b0) begin
      errors++;
      $display("FAIL lh got rData=%h err=%b expected ffff8091 0", got_rdata, got_err);
    end
    do_access(1'b1, 1'b0, 3'b100, 32'h0F, 32'h0);
    checks++;
    if (got_rdata !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu got rData=%h expected 00000080", got_rdata);
    end
    do_access(1'b1, 1'b0, 3'b010, 32'h0C, 32'h0);
    checks++;
    if (lat !== 2 || got_rdata !== 32'h8091_A2F3 || rd_hs !== 1) begin
      errors++;
      $display("FAIL lw got lat=%0d rData=%h reads=%0d expected 2 8091a2f3 1", lat, got_rdata,
               rd_hs);
    end
  endtask

  task automatic test_stores;
    do_access(1'b0, 1'b1, 3'b000, 32'h0F, 32'hAAAA_AA55);
    checks++;
    if (lat !== 3 || mem[3] !== 32'h5591_A2F3 || got_err !== 1'b0 || got_rdata !== 32'h0) begin
      errors++;
      $display("FAIL sb got lat=%0d word=%h err=%b rData=%h expected 3 5591a2f3 0 0", lat,
               mem[3], got_err, got_rdata);
    end
    checks++;
    if (rd_hs !== 1 || wr_hs !== 1 || overlap !== 0) begin
      errors++;
      $display("FAIL sb_strobes got reads=%0d writes=%0d overlap=%0d expected 1 1 0", rd_hs,
               wr_hs, overlap);
    end
    do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (lat !== 2 || mem[4] !== 32'hDEAD_BEEF || rd_hs !== 0 || wr_hs !== 1) begin
      errors++;
      $display("FAIL sw got lat=%0d word=%h reads=%0d writes=%0d expected 2 deadbeef 0 1", lat,
               mem[4], rd_hs, wr_hs);
    end
    do_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h1234_CAFE);
    checks++;
    if (lat !== 3 || mem[4] !== 32'hCAFE_BEEF || overlap !== 0) begin
      errors++;
      $display("FAIL sh got lat=%0d word=%h overlap=%0d expected 3 cafebeef 0", lat, mem[4],
               overlap);
    end
  endtask

  task automatic test_errors;
    logic [2:0]  f3s [6] = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b100, 3'b001};
    logic [31:0] as  [6] = '{32'h06, 32'h200, 32'h0C, 32'h0C, 32'h0C, 32'h0D};
    logic        rds [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        wrs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_access(rds[i], wrs[i], f3s[i], as[i], 32'hFFFF_FFFF);
      checks++;
      if (lat !== 1 || got_err !== 1'b1 || strobe_cyc !== 0 || mem[3] !== 32'h5591_A2F3) begin
        errors++;
        $display("FAIL err_case%0d got lat=%0d err=%b strobes=%0d word3=%h expected 1 1 0 5591a2f3",
                 i, lat, got_err, strobe_cyc, mem[3]);
      end
    end
  endtask

  task automatic test_timeout;
    ready_en = 1'b0;
    do_access(1'b1, 1'b0, 3'b010, 32'h0C, 32'h0);
    checks++;
    if (got_err !== 1'b1 || rd_cyc !== 16 || lat !== 17 || !stall_ok) begin
      errors++;
      $display("FAIL timeout got err=%b read_cycles=%0d lat=%0d stall_ok=%b expected 1 16 17 1",
               got_err, rd_cyc, lat, stall_ok);
    end
    ready_en = 1'b1;
  endtask

  task automatic test_reset_mid_write;
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; funct3 = 3'b001;
    addr = 32'h0E; wData = 32'h0000_1234;
    @(posedge clk);
    #1 req_valid = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_phase got mem_MemWrite=%b expected 1", mem_MemWrite);
    end
    ready_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_MemWrite !== 1'b0 || mem_MemRead !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got wr=%b rd=%b stall=%b expected 0 0 0", mem_MemWrite,
               mem_MemRead, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready_en = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || mem[3] !== 32'h5591_A2F3) begin
      errors++;
      $display("FAIL rst_after got stall=%b done=%b word3=%h expected 0 0 5591a2f3", stall, done,
               mem[3]);
    end
    do_access(1'b1, 1'b0, 3'b010, 32'h0C, 32'h0);
    checks++;
    if (lat !== 2 || got_err !== 1'b0 || got_rdata !== 32'h5591_A2F3) begin
      errors++;
      $display("FAIL rst_lw got lat=%0d err=%b rData=%h expected 2 0 5591a2f3", lat, got_err,
               got_rdata);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[3] = 32'h8091_A2F3;
    ready_en = 1'b1;
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = '0; addr = '0; wData = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
